control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit_if.sv | 34 +++
 rtl/control_unit.sv | 194 +++++++++++++++++++
 tb/tb_control_unit.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/control_unit_if.sv
// Control bus between the multicycle control FSM and the datapath/memory.
// master = control unit side (drives strobes/selects), slave = datapath side.
interface control_unit_if #(
    parameter int WIDTH         = 16,
    parameter int ALU_CONT_BITS = 5
);
    logic [WIDTH-1:0]         instruction;
    logic [WIDTH-1:0]         psr_flags;
    logic                     mem_rdy;
    logic                     ir_write;
    logic                     mem_read;
    logic                     mem_write;
    logic [1:0]               mem_addr_src;
    logic                     pc_en;
    logic                     pc_src;
    logic                     reg_write;
    logic                     reg_write_src;
    logic                     destination_reg;
    logic                     alu_A_src;
    logic [1:0]               alu_B_src;
    logic [ALU_CONT_BITS-1:0] alu_cont;

    modport master (
        input  instruction, psr_flags, mem_rdy,
        output ir_write, mem_read, mem_write, mem_addr_src, pc_en, pc_src,
               reg_write, reg_write_src, destination_reg, alu_A_src, alu_B_src, alu_cont
    );

    modport slave (
        output instruction, psr_flags, mem_rdy,
        input  ir_write, mem_read, mem_write, mem_addr_src, pc_en, pc_src,
               reg_write, reg_write_src, destination_reg, alu_A_src, alu_B_src, alu_cont
    );
endinterface

// File: rtl/control_unit.sv
// Multicycle CPU control FSM (FETCH..BR_WR); 3-5 cycles per instruction with mem_rdy high.
// FETCH, MEM_RD and MEM_WR stall with outputs held until mem_rdy, no timeout.
module control_unit #(
    parameter int WIDTH         = 16,
    parameter int ALU_CONT_BITS = 5
) (
    input  logic           clk,
    input  logic           reset,
    control_unit_if.master io_bus
);
    localparam logic [ALU_CONT_BITS-1:0] ALU_ADD   = ALU_CONT_BITS'(0);
    localparam logic [ALU_CONT_BITS-1:0] ALU_SUB   = ALU_CONT_BITS'(1);
    localparam logic [ALU_CONT_BITS-1:0] ALU_AND   = ALU_CONT_BITS'(2);
    localparam logic [ALU_CONT_BITS-1:0] ALU_OR    = ALU_CONT_BITS'(3);
    localparam logic [ALU_CONT_BITS-1:0] ALU_XOR   = ALU_CONT_BITS'(4);
    localparam logic [ALU_CONT_BITS-1:0] ALU_CMP   = ALU_CONT_BITS'(5);
    localparam logic [ALU_CONT_BITS-1:0] ALU_PASSB = ALU_CONT_BITS'(6);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_ALU_WB, S_MEM_RD, S_LOAD_WB, S_MEM_WR, S_BR_WR
    } state_t;

    state_t r_state, w_next;
    logic [4:0] r_flags;
    logic [3:0] w_op, w_a, w_ext, w_alu_code;
    logic w_alu_valid, w_is_alu, w_is_imm, w_is_cmp, w_sets_flags;
    logic w_is_load, w_is_stor, w_is_jcond, w_is_bcond, w_cond;
    logic w_n, w_z, w_f, w_l, w_c;
    logic [ALU_CONT_BITS-1:0] w_alu_sel;

    logic w_ir_write, w_mem_read, w_mem_write, w_pc_en, w_pc_src;
    logic w_reg_write, w_reg_write_src, w_alu_a_src;
    logic [1:0] w_mem_addr_src, w_alu_b_src;
    logic [ALU_CONT_BITS-1:0] w_alu_cont;

    assign w_op  = io_bus.instruction[15:12];
    assign w_a   = io_bus.instruction[11:8];
    assign w_ext = io_bus.instruction[7:4];
    assign {w_n, w_z, w_f, w_l, w_c} = r_flags;

    // Immediate forms reuse the R-type ext code as their opcode.
    always_comb begin
        w_alu_code   = (w_op == 4'b0000) ? w_ext : w_op;
        w_alu_valid  = 1'b1;
        w_alu_sel    = ALU_ADD;
        w_sets_flags = 1'b0;
        w_is_cmp     = 1'b0;
        case (w_alu_code)
            4'b0101: begin w_alu_sel = ALU_ADD; w_sets_flags = 1'b1; end
            4'b1001: begin w_alu_sel = ALU_SUB; w_sets_flags = 1'b1; end
            4'b0001: w_alu_sel = ALU_AND;
            4'b0010: w_alu_sel = ALU_OR;
            4'b0011: w_alu_sel = ALU_XOR;
            4'b1011: begin w_alu_sel = ALU_CMP; w_sets_flags = 1'b1; w_is_cmp = 1'b1; end
            4'b1101: w_alu_sel = ALU_PASSB;
            default: w_alu_valid = 1'b0;
        endcase
        w_is_alu   = w_alu_valid;
        w_is_imm   = (w_op != 4'b0000);
        w_is_load  = (w_op == 4'b0100) && (w_ext == 4'b0000);
        w_is_stor  = (w_op == 4'b0100) && (w_ext == 4'b0100);
        w_is_jcond = (w_op == 4'b0100) && (w_ext == 4'b1100);
        w_is_bcond = (w_op == 4'b1100);
    end

    always_comb begin
        w_cond = 1'b0;
        case (w_a)
            4'b0000: w_cond = w_z;
            4'b0001: w_cond = !w_z;
            4'b0010: w_cond = w_c;
            4'b0011: w_cond = !w_c;
            4'b0100: w_cond = w_l;
            4'b0101: w_cond = !w_l;
            4'b0110: w_cond = w_n;
            4'b0111: w_cond = !w_n;
            4'b1000: w_cond = w_f;
            4'b1001: w_cond = !w_f;
            4'b1010: w_cond = !w_l && !w_z;
            4'b1011: w_cond = w_l || w_z;
            4'b1100: w_cond = !w_n && !w_z;
            4'b1101: w_cond = w_n || w_z;
            4'b1110: w_cond = 1'b1;
            default: w_cond = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_FETCH;
            r_flags <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_EXEC && w_is_alu && w_sets_flags)
                r_flags <= {io_bus.psr_flags[7], io_bus.psr_flags[6], io_bus.psr_flags[5],
                            io_bus.psr_flags[2], io_bus.psr_flags[0]};
        end
    end

    always_comb begin
        w_next          = r_state;
        w_ir_write      = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_mem_addr_src  = 2'b00;
        w_pc_en         = 1'b0;
        w_pc_src        = 1'b0;
        w_reg_write     = 1'b0;
        w_reg_write_src = 1'b0;
        w_alu_a_src     = 1'b0;
        w_alu_b_src     = 2'b00;
        w_alu_cont      = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                w_mem_read = 1'b1;
                if (io_bus.mem_rdy) begin
                    w_ir_write = 1'b1;
                    w_next     = S_DECODE;
                end
            end
            S_DECODE: begin
                w_alu_b_src = 2'b10;
                w_next      = S_EXEC;
            end
            S_EXEC: begin
                w_next = S_FETCH;
                if (w_is_bcond) begin
                    // Taken branch computes pc+disp now and commits it in BR_WR.
                    if (w_cond) begin
                        w_alu_b_src = 2'b01;
                        w_next      = S_BR_WR;
                    end else begin
                        w_pc_en = 1'b1;
                    end
                end else begin
                    w_pc_en = 1'b1;
                    if (w_is_jcond) begin
                        w_pc_src = w_cond;
                    end else if (w_is_alu) begin
                        w_alu_a_src = 1'b1;
                        w_alu_b_src = w_is_imm ? 2'b01 : 2'b00;
                        w_alu_cont  = w_alu_sel;
                        if (!w_is_cmp)
                            w_next = S_ALU_WB;
                    end else if (w_is_load) begin
                        w_next = S_MEM_RD;
                    end else if (w_is_stor) begin
                        w_next = S_MEM_WR;
                    end
                end
            end
            S_ALU_WB: begin
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEM_RD: begin
                w_mem_read     = 1'b1;
                w_mem_addr_src = 2'b01;
                if (io_bus.mem_rdy)
                    w_next = S_LOAD_WB;
            end
            S_LOAD_WB: begin
                w_reg_write     = 1'b1;
                w_reg_write_src = 1'b1;
                w_next          = S_FETCH;
            end
            S_MEM_WR: begin
                w_mem_write    = 1'b1;
                w_mem_addr_src = 2'b10;
                if (io_bus.mem_rdy)
                    w_next = S_FETCH;
            end
            S_BR_WR: begin
                w_pc_en = 1'b1;
                w_next  = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // All strobes are forced low while reset is held.
    assign io_bus.ir_write        = reset & w_ir_write;
    assign io_bus.mem_read        = reset & w_mem_read;
    assign io_bus.mem_write       = reset & w_mem_write;
    assign io_bus.mem_addr_src    = reset ? w_mem_addr_src : 2'b00;
    assign io_bus.pc_en           = reset & w_pc_en;
    assign io_bus.pc_src          = reset & w_pc_src;
    assign io_bus.reg_write       = reset & w_reg_write;
    assign io_bus.reg_write_src   = reset & w_reg_write_src;
    assign io_bus.destination_reg = 1'b0;
    assign io_bus.alu_A_src       = reset & w_alu_a_src;
    assign io_bus.alu_B_src       = reset ? w_alu_b_src : 2'b00;
    assign io_bus.alu_cont        = reset ? w_alu_cont : ALU_ADD;
endmodule

// File: tb/tb_control_unit.sv
// Scoreboarded random/directed bench for control_unit against an instruction-level model.
module tb_control_unit;
    typedef struct packed {
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_addr_src;
        logic       pc_en;
        logic       pc_src;
        logic       reg_write;
        logic       reg_write_src;
        logic       destination_reg;
        logic       alu_a_src;
        logic [1:0] alu_b_src;
        logic [4:0] alu_cont;
    } out_t;

    typedef struct packed {
        logic        rst_n;
        logic        rdy;
        logic [15:0] instr;
        logic [15:0] psr;
        out_t        exp;
    } cyc_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    control_unit_if #(.WIDTH(16), .ALU_CONT_BITS(5)) bus ();

    control_unit #(.WIDTH(16), .ALU_CONT_BITS(5)) dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    cyc_t stim_q[$];
    out_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_no = 0;
    logic [4:0] m_flags = '0;   // {N,Z,F,L,C}
    logic [3:0] alu_codes [7] = '{4'h5, 4'h9, 4'h1, 4'h2, 4'h3, 4'hB, 4'hD};

    function automatic logic cond_holds(input logic [3:0] c, input logic [4:0] f);
        logic n, z, fl, l, cy;
        logic [15:0] t;
        {n, z, fl, l, cy} = f;
        t = {1'b0, 1'b1, n | z, !n & !z, l | z, !l & !z, !fl, fl,
             !n, n, !l, l, !cy, cy, !z, z};
        return t[c];
    endfunction

    function automatic cyc_t mk(input logic rst_n, input logic rdy, input logic [15:0] ins,
                                input logic [15:0] psr, input out_t e);
        cyc_t c;
        c.rst_n = rst_n; c.rdy = rdy; c.instr = ins; c.psr = psr; c.exp = e;
        return c;
    endfunction

    task automatic add_reset(input int n);
        for (int i = 0; i < n; i++)
            stim_q.push_back(mk(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), '0));
        m_flags = '0;
    endtask

    // Build the expected cycle-by-cycle outputs of one instruction; cut>0 truncates it.
    task automatic gen(input logic [15:0] ins, input logic [15:0] psr,
                       input int fwait, input int mwait, input int cut);
        cyc_t seq[$];
        out_t e;
        logic [3:0] op, a, ext, code;
        int k, exec_idx, n;
        logic upd;
        op = ins[15:12]; a = ins[11:8]; ext = ins[7:4];
        code = (op == 4'h0) ? ext : op;
        k = -1;
        for (int i = 0; i < 7; i++) if (alu_codes[i] == code) k = i;
        upd = 1'b0;

        for (int i = 0; i < fwait; i++) begin
            e = '0; e.mem_read = 1'b1;
            seq.push_back(mk(1'b1, 1'b0, ins, psr, e));
        end
        e = '0; e.mem_read = 1'b1; e.ir_write = 1'b1;
        seq.push_back(mk(1'b1, 1'b1, ins, psr, e));
        e = '0; e.alu_b_src = 2'd2;
        seq.push_back(mk(1'b1, 1'($urandom_range(0, 1)), ins, psr, e));

        exec_idx = seq.size();
        e = '0;
        if (k >= 0) begin
            e.pc_en = 1'b1; e.alu_a_src = 1'b1;
            e.alu_b_src = (op == 4'h0) ? 2'd0 : 2'd1;
            e.alu_cont = 5'(k);
            seq.push_back(mk(1'b1, 1'($urandom_range(0, 1)), ins, psr, e));
            upd = (k < 2) || (k == 5);
            if (k != 5) begin
                e = '0; e.reg_write = 1'b1;
                seq.push_back(mk(1'b1, 1'($urandom_range(0, 1)), ins, psr, e));
            end
        end else if (op == 4'h4 && (ext == 4'h0 || ext == 4'h4)) begin
            e.pc_en = 1'b1;
            seq.push_back(mk(1'b1, 1'($urandom_range(0, 1)), ins, psr, e));
            e = '0;
            if (ext == 4'h0) begin e.mem_read = 1'b1; e.mem_addr_src = 2'd1; end
            else begin e.mem_write = 1'b1; e.mem_addr_src = 2'd2; end
            for (int i = 0; i < mwait; i++) seq.push_back(mk(1'b1, 1'b0, ins, psr, e));
            seq.push_back(mk(1'b1, 1'b1, ins, psr, e));
            if (ext == 4'h0) begin
                e = '0; e.reg_write = 1'b1; e.reg_write_src = 1'b1;
                seq.push_back(mk(1'b1, 1'($urandom_range(0, 1)), ins, psr, e));
            end
        end else if (op == 4'h4 && ext == 4'hC) begin
            e.pc_en = 1'b1; e.pc_src = cond_holds(a, m_flags);
            seq.push_back(mk(1'b1, 1'($urandom_range(0, 1)), ins, psr, e));
        end else if (op == 4'hC && cond_holds(a, m_flags)) begin
            e.alu_b_src = 2'd1;
            seq.push_back(mk(1'b1, 1'($urandom_range(0, 1)), ins, psr, e));
            e = '0; e.pc_en = 1'b1;
            seq.push_back(mk(1'b1, 1'($urandom_range(0, 1)), ins, psr, e));
        end else begin
            e.pc_en = 1'b1;
            seq.push_back(mk(1'b1, 1'($urandom_range(0, 1)), ins, psr, e));
        end

        n = (cut > 0 && cut < seq.size()) ? cut : seq.size();
        for (int i = 0; i < n; i++) stim_q.push_back(seq[i]);
        if (upd && n > exec_idx)
            m_flags = {psr[7], psr[6], psr[5], psr[2], psr[0]};
    endtask

    always @(negedge clk) begin
        out_t e, got;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = {bus.ir_write, bus.mem_read, bus.mem_write, bus.mem_addr_src, bus.pc_en,
                   bus.pc_src, bus.reg_write, bus.reg_write_src, bus.destination_reg,
                   bus.alu_A_src, bus.alu_B_src, bus.alu_cont};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL outputs cycle=%0d got=%05h expected=%05h", cyc_no, got, e);
            end
        end
    end

    initial begin
        logic [15:0] ins;
        int r;
        bus.instruction = '0;
        bus.psr_flags   = '0;
        bus.mem_rdy     = 1'b0;

        add_reset(2);
        gen(16'h0152, 16'h0000, 0, 0, 0);        // ADD R1,R2
        gen(16'h4304, 16'h0000, 1, 3, 0);        // LOAD with 3 wait cycles
        gen(16'h01B2, 16'h0040, 0, 0, 0);        // CMP -> Z
        gen(16'hC005, 16'h0000, 0, 0, 0);        // BEQ taken
        gen(16'h01B2, 16'h0000, 0, 0, 0);
        gen(16'hC005, 16'h0000, 0, 0, 0);        // BEQ not taken
        gen(16'h4EC5, 16'h0000, 0, 0, 0);        // JUC
        gen(16'h4FC5, 16'h0000, 0, 0, 0);        // never
        gen(16'h01B2, 16'h0040, 0, 0, 0);
        gen(16'h4342, 16'h0000, 0, 5, 5);        // STOR cut mid-wait
        add_reset(1);
        gen(16'hC005, 16'h0000, 0, 0, 0);        // flags cleared: not taken
        gen(16'hF000, 16'h0000, 0, 0, 0);        // undefined -> NOP

        for (int i = 0; i < 300; i++) begin
            ins = 16'($urandom);
            r = $urandom_range(0, 9);
            case (r)
                2, 3: begin ins[15:12] = 4'h0; ins[7:4] = alu_codes[$urandom_range(0, 6)]; end
                4:    ins[15:12] = alu_codes[$urandom_range(0, 6)];
                5:    begin ins[15:12] = 4'h4; ins[7:4] = 4'h0; end
                6:    begin ins[15:12] = 4'h4; ins[7:4] = 4'h4; end
                7:    begin ins[15:12] = 4'h4; ins[7:4] = 4'hC; end
                8:    ins[15:12] = 4'hC;
                default: ;
            endcase
            if (r == 9) begin
                gen(ins, 16'($urandom), $urandom_range(0, 2), $urandom_range(0, 3),
                    $urandom_range(1, 6));
                add_reset($urandom_range(1, 2));
            end else begin
                gen(ins, 16'($urandom), $urandom_range(0, 2), $urandom_range(0, 3), 0);
            end
        end

        while (stim_q.size() > 0) begin
            cyc_t c;
            c = stim_q.pop_front();
            @(posedge clk);
            #1;
            cyc_no++;
            reset           = c.rst_n;
            bus.mem_rdy     = c.rdy;
            bus.instruction = c.instr;
            bus.psr_flags   = c.psr;
            exp_q.push_back(c.exp);
        end
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
